// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed on the start edge and held in shadow registers until the busy window ends.
module mult_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [7:0]         count;
  logic [WIDTH-1:0]   shadow_hi;
  logic [WIDTH-1:0]   shadow_lo;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               div_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   div_b;
  logic [WIDTH-1:0]   uquot;
  logic [WIDTH-1:0]   urem;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of the unsigned product equal the signed product.
  assign prod_s = {{WIDTH{in1[WIDTH-1]}}, in1} * {{WIDTH{in2[WIDTH-1]}}, in2};
  assign prod_u = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};

  // Signed division via magnitudes; most-negative / -1 wraps back to most-negative with no trap.
  assign div_signed = (op == OP_DIV);
  assign a_neg      = div_signed & in1[WIDTH-1];
  assign b_neg      = div_signed & in2[WIDTH-1];
  assign mag_a      = a_neg ? -in1 : in1;
  assign mag_b      = b_neg ? -in2 : in2;
  assign div_b      = (in2 == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
  assign uquot      = mag_a / div_b;
  assign urem       = mag_a % div_b;
  assign quot       = (a_neg ^ b_neg) ? -uquot : uquot;
  assign rem        = a_neg ? -urem : urem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= 8'd0;
      shadow_hi <= '0;
      shadow_lo <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                {shadow_hi, shadow_lo} <= (op == OP_MULT) ? prod_s : prod_u;
                count <= 8'(MUL_CYCLES);
                state <= BUSY;
                busy  <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                // A zero divisor still occupies the unit but writes back the current HI/LO.
                if (in2 == '0) begin
                  shadow_hi <= hi;
                  shadow_lo <= lo;
                end else begin
                  shadow_hi <= rem;
                  shadow_lo <= quot;
                end
                count <= 8'(DIV_CYCLES);
                state <= BUSY;
                busy  <= 1'b1;
              end
              OP_MTHI: hi <= in1;
              OP_MTLO: lo <= in1;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (count <= 8'd1) begin
            hi    <= shadow_hi;
            lo    <= shadow_lo;
            count <= 8'd0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            count <= count - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: a result table plus hand-written busy/reset/back-to-back sequences.
module tb_mult_div_unit;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  vec_t vecs[8];

  mult_div_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issues an op, follows the busy window and returns in the done cycle.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int n, input logic [31:0] e_hi, input logic [31:0] e_lo,
                       input string nm);
    int cyc;
    chk({nm, " busy_in_start_cycle"}, 64'(busy), 64'd0);
    start = 1'b1; op = o; in1 = a; in2 = b;
    step();
    start = 1'b0; op = OP_NOP;
    cyc = 0;
    while (busy === 1'b1 && cyc < 300) begin
      cyc++;
      chk({nm, " hold_hi"}, 64'(hi), 64'(model_hi));
      chk({nm, " hold_lo"}, 64'(lo), 64'(model_lo));
      chk({nm, " done_during_busy"}, 64'(done), 64'd0);
      step();
    end
    chk({nm, " busy_cycles"}, 64'(cyc), 64'(n));
    chk({nm, " done_pulse"}, 64'(done), 64'd1);
    chk({nm, " hi"}, 64'(hi), 64'(e_hi));
    chk({nm, " lo"}, 64'(lo), 64'(e_lo));
    model_hi = e_hi;
    model_lo = e_lo;
    $display("op=%0h in1=%08h in2=%08h -> hi=%08h lo=%08h busy_cycles=%0d (%s)", o, a, b, hi, lo, cyc, nm);
  endtask

  task automatic mv(input logic [3:0] o, input logic [31:0] v, input string nm);
    start = 1'b1; op = o; in1 = v;
    step();
    start = 1'b0; op = OP_NOP;
    if (o == OP_MTHI) model_hi = v;
    else model_lo = v;
    chk({nm, " busy"}, 64'(busy), 64'd0);
    chk({nm, " done"}, 64'(done), 64'd0);
    chk({nm, " hi"}, 64'(hi), 64'(model_hi));
    chk({nm, " lo"}, 64'(lo), 64'(model_lo));
    $display("move op=%0h value=%08h -> hi=%08h lo=%08h (%s)", o, v, hi, lo, nm);
  endtask

  initial begin
    int cyc;
    int done_seen;

    vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'h00000003, 5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2] = '{OP_DIVU,  32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
    vecs[3] = '{OP_MULTU, 32'h00010000, 32'h00010000, 5,  32'h00000001, 32'h00000000};
    vecs[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[5] = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{OP_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
    vecs[7] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].e_hi, vecs[i].e_lo, $sformatf("vec%0d", i));
      step();
      chk($sformatf("vec%0d done_single_cycle", i), 64'(done), 64'd0);
    end

    // Divide by zero leaves preloaded HI/LO intact
    mv(OP_MTHI, 32'h11, "mthi");
    mv(OP_MTLO, 32'h22, "mtlo");
    do_op(OP_DIV, 32'h1234, 32'h0, 10, 32'h11, 32'h22, "div_by_zero");
    step();

    // NOP encodings do nothing
    for (int k = 0; k < 3; k++) begin
      logic [3:0] nop_ops [3];
      nop_ops = '{4'h0, 4'h7, 4'hF};
      start = 1'b1; op = nop_ops[k]; in1 = 32'hDEADBEEF; in2 = 32'h1;
      step();
      start = 1'b0; op = OP_NOP;
      chk($sformatf("nop%0d busy", k), 64'(busy), 64'd0);
      chk($sformatf("nop%0d hi", k), 64'({hi, lo}), 64'({model_hi, model_lo}));
      $display("nop op=%0h -> hi=%08h lo=%08h busy=%0b", nop_ops[k], hi, lo, busy);
    end

    // MULTU with a MTLO issued while busy, which must be dropped
    start = 1'b1; op = OP_MULTU; in1 = 32'hFFFFFFFF; in2 = 32'hFFFFFFFF;
    step();
    chk("multu_mtlo busy1", 64'(busy), 64'd1);
    op = OP_MTLO; in1 = 32'h5;
    step();
    start = 1'b0; op = OP_NOP;
    chk("multu_mtlo lo_unchanged", 64'(lo), 64'(model_lo));
    cyc = 1;
    while (busy === 1'b1 && cyc < 300) begin
      cyc++;
      step();
    end
    chk("multu_mtlo busy_cycles", 64'(cyc), 64'd5);
    chk("multu_mtlo done", 64'(done), 64'd1);
    chk("multu_mtlo hi", 64'(hi), 64'hFFFFFFFE);
    chk("multu_mtlo lo", 64'(lo), 64'h00000001);
    model_hi = 32'hFFFFFFFE; model_lo = 32'h00000001;
    $display("multu+mtlo -> hi=%08h lo=%08h busy_cycles=%0d", hi, lo, cyc);
    step();

    // Back-to-back: second start lands in the done cycle of the first
    do_op(OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3, "b2b_first");
    do_op(OP_MULTU, 32'd2, 32'd3, 5, 32'd0, 32'd6, "b2b_second");
    step();
    chk("b2b done_cleared", 64'(done), 64'd0);

    // Reset asserted on the third busy cycle of a MULT
    start = 1'b1; op = OP_MULT; in1 = 32'd9; in2 = 32'd9;
    step();
    start = 1'b0; op = OP_NOP;
    step();
    step();
    chk("abort busy_before_reset", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    model_hi = 32'd0; model_lo = 32'd0;
    $display("reset during busy -> busy=%0b done=%0b hi=%08h lo=%08h", busy, done, hi, lo);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1; op = OP_MTHI; in1 = 32'hABC;
    step();
    start = 1'b0; op = OP_NOP;
    chk("first_start_after_reset hi", 64'(hi), 64'hABC);
    model_hi = 32'hABC;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) done_seen++;
      step();
    end
    chk("abort no_late_done", 64'(done_seen), 64'd0);
    chk("abort no_late_update", 64'({hi, lo}), 64'({model_hi, model_lo}));
    $display("after abort release -> done_pulses=%0d hi=%08h lo=%08h", done_seen, hi, lo);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and HI/LO register width in bits.
REQ-002 Parameter: MUL_CYCLES, default 5, busy duration of MULT/MULTU in cycles (legal range 1..255).
REQ-003 Parameter: DIV_CYCLES, default 10, busy duration of DIV/DIVU in cycles (legal range 1..255).
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  qualifies op for one cycle.
REQ-007 Port: op  input  4  operation select, with these encodings:
- 0001 MULT
- 0010 MULTU
- 0011 DIV
- 0100 DIVU
- 0101 MTHI
- 0110 MTLO
- all others NOP.
REQ-008 Port: in1  input  WIDTH  operand A / dividend / move source.
REQ-009 Port: in2  input  WIDTH  operand B / divisor.
REQ-010 Port: busy  output  1  high while a mult/div is in flight.
REQ-011 Port: done  output  1  one-cycle pulse on the cycle HI/LO take a mult/div result.
REQ-012 Port: hi  output  WIDTH  architectural HI register.
REQ-013 Port: lo  output  WIDTH  architectural LO register.

Function
REQ-014 The block SHALL implement a two-state FSM, IDLE and BUSY, plus an 8-bit cycle counter.
REQ-015 In IDLE, start=1 with MULT/MULTU/DIV/DIVU SHALL have the following effect on that edge:
- latch the full result into internal shadow registers;
- load the counter with MUL_CYCLES or DIV_CYCLES;
- enter BUSY.
REQ-016 busy SHALL equal (state==BUSY) as a registered output: low in the start cycle, high from the next cycle for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES).
REQ-017 On the edge ending the Nth busy cycle, the block SHALL copy shadow HI/LO to hi/lo, return to IDLE, and pulse done high for the following single cycle.
REQ-018 hi/lo SHALL hold their previous values throughout BUSY; intermediate results are never visible.
REQ-019 While busy=1, start SHALL be ignored for every op: no queuing, no state change.
REQ-020 In IDLE, MTHI/MTLO with start=1 SHALL write in1 to hi or lo on that edge, with busy and done staying 0.
REQ-021 In IDLE, a NOP op with start=1 SHALL have no effect.
REQ-022 MULT SHALL compute the signed WIDTHxWIDTH product to 2*WIDTH bits: hi = upper WIDTH bits, lo = lower WIDTH bits.
REQ-023 MULTU SHALL compute the same split on the unsigned product.
REQ-024 DIV SHALL compute the signed quotient into lo, truncated toward zero, and the remainder into hi, carrying the sign of the dividend.
REQ-025 DIVU SHALL compute the unsigned quotient into lo and the remainder into hi.
REQ-026 For DIV/DIVU with in2==0, the block SHALL still run the full DIV_CYCLES and pulse done, but leave hi/lo unchanged.
REQ-027 For DIV with in1 = most-negative value and in2 = -1, the block SHALL produce lo = most-negative value and hi = 0, with no trap.
REQ-028 A start on the same cycle that done is high SHALL be accepted, because state is already IDLE.

Reset
REQ-029 While reset=0, the block SHALL immediately force the following, independent of clk:
- state = IDLE
- counter = 0
- shadow registers = 0
- busy = 0
- done = 0
- hi = 0
- lo = 0
REQ-030 Reset asserted during BUSY SHALL abort the operation with no done pulse and no later HI/LO update.
REQ-031 The first start after reset deassertion SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-032 The bench SHALL cover MULT with in1=0xFFFFFFFE (-2), in2=3 at defaults: busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, and done high for 1 cycle.
REQ-033 The bench SHALL cover DIV with in1=0xFFFFFFF9 (-7), in2=2: after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 The bench SHALL cover DIVU with in1=7, in2=2: lo=3, hi=1.
REQ-035 The bench SHALL cover DIV with in2=0, with hi=0x11 and lo=0x22 preloaded via MTHI/MTLO: after 10 cycles done pulses and hi/lo remain 0x11/0x22.
REQ-036 The bench SHALL cover MULTU 0xFFFFFFFF x 0xFFFFFFFF, followed on the next cycle by start+MTLO with in1=0x5: the MTLO is ignored; final hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 The bench SHALL cover reset=0 asserted on the 3rd busy cycle of a MULT: busy, done, hi and lo are 0 immediately, and no done pulse follows after release.
REQ-038 The bench SHALL cover back-to-back operation with start+MULTU 2x3 asserted in the done cycle of a prior op: it is accepted, and after 5 cycles lo=6, hi=0.
